if_fetch_unit: RTL and testbench

//   Parametrised instruction-fetch stage for the MIPS pipeline. Replaces the
//   pc_reg + if_id pair. Drives a synchronous instruction ROM with one-cycle

---
 rtl/if_fetch_unit_pkg.sv | 22 ++
 rtl/if_fetch_unit_fetch_fifo.sv | 75 +++++++
 rtl/if_fetch_unit.sv | 101 ++++++++++
 tb/tb_if_fetch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared constants and helpers for the instruction-fetch stage
// Purpose: reset/chip-enable levels, default bus widths used as parameter
//          defaults, and the queue-credit helper used by the fetch stage.
// Ports:   none (package).
package if_fetch_unit_pkg;

  localparam logic RST_ENABLE   = 1'b0;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  localparam int INST_ADDR_BUS_W = 32;
  localparam int INST_BUS_W      = 32;

  // True when one more request fits: queued entries plus the in-flight
  // response must stay below the queue depth, so a push never overflows.
  function automatic logic credit_ok(input int unsigned count,
                                     input int unsigned inflight,
                                     input int unsigned depth);
    return (count + inflight) < depth;
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// rtl/if_fetch_unit_fetch_fifo.sv - synchronous fetch queue with flush
// Purpose: DEPTH x W synchronous FIFO holding fetched {pc, inst} entries.
//          Flush has priority over push and pop.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous reset, active-low
//   push       in   write push_data at the tail
//   push_data  in   W-bit entry
//   pop        in   drop the head entry
//   flush      in   empty the queue (wins over push/pop)
//   head_data  out  W-bit head entry (unqualified; valid when count != 0)
//   count      out  occupancy, $clog2(DEPTH)+1 bits
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic do_push;
  logic do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush;

  // Storage needs no reset: entries are only observed through count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch stage with ROM interface and fetch queue
// Purpose: issues sequential reads to a 1-cycle-latency instruction ROM,
//          queues {pc, inst} and hands the head entry to decode with a
//          valid/ready handshake; a redirect flushes all wrong-path work.
// Ports:
//   clk, rst        clock; asynchronous reset, active-low
//   rom_ce_o        ROM read request this cycle
//   rom_addr_o      ROM read address (fetch PC)
//   rom_data_i      ROM data, valid the cycle after rom_ce_o
//   redirect_i      redirect fetch to redirect_pc_i and flush
//   redirect_pc_i   redirect target (used unaligned as given)
//   id_ready_i      decode accepts the head entry
//   id_valid_o      head entry valid
//   id_pc_o         head entry PC (0 when empty)
//   id_inst_o       head entry instruction (0 when empty)
//   fq_count_o      queue occupancy
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_BUS_W,
  parameter int                INST_W   = INST_BUS_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     rom_ce_o,
  output logic [ADDR_W-1:0]        rom_addr_o,
  input  logic [INST_W-1:0]        rom_data_i,
  input  logic                     redirect_i,
  input  logic [ADDR_W-1:0]        redirect_pc_i,
  input  logic                     id_ready_i,
  output logic                     id_valid_o,
  output logic [ADDR_W-1:0]        id_pc_o,
  output logic [INST_W-1:0]        id_inst_o,
  output logic [$clog2(DEPTH):0]   fq_count_o
);

  localparam int EW = ADDR_W + INST_W;

  logic [ADDR_W-1:0]      fetch_pc;
  logic                   inflight;
  logic [ADDR_W-1:0]      inflight_pc;
  logic                   drop;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic [EW-1:0]          head_data;
  logic [$clog2(DEPTH):0] count;

  // Gated by rst so no request leaks out while reset is held.
  assign issue = (rst != RST_ENABLE) && !redirect_i &&
                 credit_ok(int'(count), int'(inflight), DEPTH);

  // A redirect discards the response of the request issued before it.
  assign drop = redirect_i;
  assign push = inflight && !drop;

  assign id_valid_o = (count != '0);
  assign pop        = id_valid_o && id_ready_i && !redirect_i;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_i) begin
      fetch_pc    <= redirect_pc_i;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + ADDR_W'(PC_STEP);
        inflight_pc <= fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({inflight_pc, rom_data_i}),
    .pop       (pop),
    .flush     (redirect_i),
    .head_data (head_data),
    .count     (count)
  );

  assign rom_ce_o   = issue ? CHIP_ENABLE : CHIP_DISABLE;
  assign rom_addr_o = fetch_pc;
  assign id_pc_o    = id_valid_o ? head_data[EW-1:INST_W] : '0;
  assign id_inst_o  = id_valid_o ? head_data[INST_W-1:0] : '0;
  assign fq_count_o = count;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a: RESET_PC = 0
  logic        rst = 1'b0;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  fq_count;

  // Instance b: RESET_PC = FFFF_FFF8
  logic        rst_b = 1'b0;
  logic        rom_ce_b;
  logic [31:0] rom_addr_b;
  logic [31:0] rom_data_b = '0;
  logic        id_ready_b = 1'b1;
  logic        id_valid_b;
  logic [31:0] id_pc_b;
  logic [31:0] id_inst_b;
  logic [2:0]  fq_count_b;

  int checks = 0;
  int errors = 0;

  if_fetch_unit u_dut (
    .clk           (clk),
    .rst           (rst),
    .rom_ce_o      (rom_ce),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .id_ready_i    (id_ready),
    .id_valid_o    (id_valid),
    .id_pc_o       (id_pc),
    .id_inst_o     (id_inst),
    .fq_count_o    (fq_count)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_b (
    .clk           (clk),
    .rst           (rst_b),
    .rom_ce_o      (rom_ce_b),
    .rom_addr_o    (rom_addr_b),
    .rom_data_i    (rom_data_b),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .id_ready_i    (id_ready_b),
    .id_valid_o    (id_valid_b),
    .id_pc_o       (id_pc_b),
    .id_inst_o     (id_inst_b),
    .fq_count_o    (fq_count_b)
  );

  // ROM models: inst = addr ^ A5A5_0000, one-cycle latency.
  always @(posedge clk) begin
    if (rom_ce)   rom_data   <= rom_addr ^ 32'hA5A5_0000;
    if (rom_ce_b) rom_data_b <= rom_addr_b ^ 32'hA5A5_0000;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 64'(id_valid), 64'd1);
    check({tag, "_pc"},    64'(id_pc),    64'(pc));
    check({tag, "_inst"},  64'(id_inst),  64'(pc ^ 32'hA5A5_0000));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    redirect = 1'b0;
    tick();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_ce",    64'(rom_ce),   64'd0);
    check("rst_valid", 64'(id_valid), 64'd0);
    check("rst_pc",    64'(id_pc),    64'd0);
    check("rst_inst",  64'(id_inst),  64'd0);
    check("rst_count", 64'(fq_count), 64'd0);

    // 1: startup with decode always ready
    id_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("t1_ce0",   64'(rom_ce),   64'd1);
    check("t1_addr0", 64'(rom_addr), 64'd0);
    tick();
    check("t1_novalid", 64'(id_valid), 64'd0);
    check("t1_addr1",   64'(rom_addr), 64'd4);
    tick();
    for (int i = 0; i < 6; i++) begin
      check_head($sformatf("t1_%0d", i), 32'(4 * i));
      check("t1_count", 64'(fq_count), 64'd1);
      tick();
    end

    // 2: decode stalled, credit limits issue to DEPTH
    id_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_ce%0d", i),   64'(rom_ce),   64'd1);
      check($sformatf("t2_addr%0d", i), 64'(rom_addr), 64'(4 * i));
      tick();
    end
    check("t2_ce_off", 64'(rom_ce), 64'd0);
    for (int i = 0; i < 6; i++) tick();
    check("t2_full",  64'(fq_count), 64'd4);
    check("t2_ce_st", 64'(rom_ce),   64'd0);
    id_ready = 1'b1;
    #1;
    for (int i = 0; i < 9; i++) begin
      check_head($sformatf("t2_%0d", i), 32'(4 * i));
      tick();
    end

    // 3: redirect with 3 queued + 1 in flight
    id_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    check("t3_count3", 64'(fq_count), 64'd3);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    #1;
    check("t3_ce_redir", 64'(rom_ce), 64'd0);
    tick();
    redirect = 1'b0;
    #1;
    check("t3_valid0", 64'(id_valid), 64'd0);
    check("t3_count0", 64'(fq_count), 64'd0);
    check("t3_ce",     64'(rom_ce),   64'd1);
    check("t3_addr",   64'(rom_addr), 64'h100);
    tick();
    check("t3_valid1", 64'(id_valid), 64'd0);
    tick();
    check_head("t3_tgt", 32'h100);
    id_ready = 1'b1;
    tick();
    check_head("t3_tgt1", 32'h104);

    // 4: redirect coincident with a pop and a push
    do_reset();
    tick();
    tick();
    tick();
    check_head("t4_pre", 32'h4);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    #1;
    check("t4_count", 64'(fq_count), 64'd0);
    check("t4_valid", 64'(id_valid), 64'd0);
    tick();
    check("t4_valid2", 64'(id_valid), 64'd0);
    tick();
    check_head("t4_tgt", 32'h200);
    tick();
    check_head("t4_tgt1", 32'h204);

    // 5: reset asserted mid-stream
    tick();
    rst = 1'b0;
    #1;
    check("t5_ce",    64'(rom_ce),   64'd0);
    check("t5_valid", 64'(id_valid), 64'd0);
    check("t5_pc",    64'(id_pc),    64'd0);
    check("t5_inst",  64'(id_inst),  64'd0);
    check("t5_count", 64'(fq_count), 64'd0);
    tick();
    rst = 1'b1;
    #1;
    check("t5_addr", 64'(rom_addr), 64'd0);
    tick();
    tick();
    check_head("t5_restart", 32'h0);

    // 6: RESET_PC near the top of the address space wraps
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    #1;
    check("t6_addr", 64'(rom_addr_b), 64'hFFFF_FFF8);
    tick();
    tick();
    check("t6_pc0",   64'(id_pc_b),   64'hFFFF_FFF8);
    check("t6_inst0", 64'(id_inst_b), 64'h5A5A_FFF8);
    tick();
    check("t6_pc1",   64'(id_pc_b),   64'hFFFF_FFFC);
    check("t6_inst1", 64'(id_inst_b), 64'h5A5A_FFFC);
    tick();
    check("t6_pc2",   64'(id_pc_b),   64'h0);
    check("t6_inst2", 64'(id_inst_b), 64'hA5A5_0000);
    check("t6_valid", 64'(id_valid_b), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
